// File: rtl/calc_datapath_if.sv
`default_nettype none
// ============================================================================
//  Module   : calc_datapath_if
//  Brief    : Control-word and result bundle between the calculator control
//             FSM (master) and the calculator datapath (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface calc_datapath_if #(
   parameter int W = 4
);
   // Operands and control word driven by the FSM side
   logic [W-1:0] in1;
   logic [W-1:0] in2;
   logic [1:0]   s1;
   logic [1:0]   WA;
   logic         WE;
   logic [1:0]   RAA;
   logic [1:0]   RAB;
   logic         REA;
   logic         REB;
   logic [1:0]   C;
   logic         s2;
   // Held results returned by the datapath
   logic [W-1:0] out;
   logic         carry;
   logic         zero;
   logic         valid;

   modport master (
      output in1, in2, s1, WA, WE, RAA, RAB, REA, REB, C, s2,
      input  out, carry, zero, valid
   );

   modport slave (
      input  in1, in2, s1, WA, WE, RAA, RAB, REA, REB, C, s2,
      output out, carry, zero, valid
   );
endinterface
`default_nettype wire

// File: rtl/calc_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : calc_datapath
//  Brief    : Calculator datapath: 4-entry register file, input mux, 2-bit-op
//             ALU, output mux and held result/flag registers.
//  Revision : 1.0 - initial release
// ============================================================================
module calc_datapath #(
   parameter int W = 4
) (
   input  wire logic       clk,
   input  wire logic       rst,
   calc_datapath_if.slave  bus
);

   localparam logic [1:0] C_MUX1_ALU  = 2'd0;
   localparam logic [1:0] C_MUX1_ZERO = 2'd1;
   localparam logic [1:0] C_MUX1_IN2  = 2'd2;
   localparam logic [1:0] C_MUX1_IN1  = 2'd3;

   localparam logic [1:0] C_OP_ADD = 2'd0;
   localparam logic [1:0] C_OP_SUB = 2'd1;
   localparam logic [1:0] C_OP_AND = 2'd2;
   localparam logic [1:0] C_OP_XOR = 2'd3;

   // Register file: R0 is an ordinary writable entry
   logic [W-1:0] rf_q [4];

   logic [W-1:0] out_q;
   logic         carry_q;
   logic         zero_q;
   logic         valid_q;

   logic [W-1:0] w_rd_a;
   logic [W-1:0] w_rd_b;
   logic [W:0]   w_sum;
   logic [W:0]   w_diff;
   logic [W-1:0] w_alu_res;
   logic         w_alu_cout;
   logic [W-1:0] w_mux1;
   logic         w_flag_upd;

   // Gated combinational read ports; writes land on the edge, so a same-cycle
   // read of the written address still sees the old contents
   always_comb begin
      w_rd_a = '0;
      w_rd_b = '0;
      if (bus.REA) w_rd_a = rf_q[bus.RAA];
      if (bus.REB) w_rd_b = rf_q[bus.RAB];
   end

   // ALU: W+1-bit add/sub expose carry-out and borrow in the top bit
   always_comb begin
      w_sum      = {1'b0, w_rd_a} + {1'b0, w_rd_b};
      w_diff     = {1'b0, w_rd_a} - {1'b0, w_rd_b};
      w_alu_res  = '0;
      w_alu_cout = 1'b0;
      case (bus.C)
         C_OP_ADD: begin
            w_alu_res  = w_sum[W-1:0];
            w_alu_cout = w_sum[W];
         end
         C_OP_SUB: begin
            w_alu_res  = w_diff[W-1:0];
            w_alu_cout = w_diff[W];
         end
         C_OP_AND: w_alu_res = w_rd_a & w_rd_b;
         C_OP_XOR: w_alu_res = w_rd_a ^ w_rd_b;
         default:  w_alu_res = '0;
      endcase
   end

   // Input mux selecting what gets written back into the register file
   always_comb begin
      w_mux1 = '0;
      case (bus.s1)
         C_MUX1_ALU:  w_mux1 = w_alu_res;
         C_MUX1_ZERO: w_mux1 = '0;
         C_MUX1_IN2:  w_mux1 = bus.in2;
         C_MUX1_IN1:  w_mux1 = bus.in1;
         default:     w_mux1 = '0;
      endcase
   end

   // Flags only track ALU results that are actually written back
   assign w_flag_upd = bus.WE && (bus.s1 == C_MUX1_ALU);

   // Register file write port; reset drops any write on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) rf_q[i] <= '0;
      end else if (bus.WE) begin
         rf_q[bus.WA] <= w_mux1;
      end
   end

   // Held flags, captured on ALU writeback
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
      end else if (w_flag_upd) begin
         carry_q <= w_alu_cout;
         zero_q  <= (w_alu_res == '0);
      end
   end

   // Output mux/register: s2 captures the ALU result, otherwise holds
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q   <= '0;
         valid_q <= 1'b0;
      end else if (bus.s2) begin
         out_q   <= w_alu_res;
         valid_q <= 1'b1;
      end
   end

   assign bus.out   = out_q;
   assign bus.carry = carry_q;
   assign bus.zero  = zero_q;
   assign bus.valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calc_datapath
//  Brief    : Scoreboard bench for calc_datapath driving full FSM sequences,
//             resets, read-before-write and read-enable gating.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_calc_datapath;

   localparam int W = 4;

   typedef struct {
      string      tag;
      logic [3:0] out;
      logic       carry;
      logic       zero;
      logic       valid;
      bit         flags;
   } exp_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   exp_t sb_q[$];

   calc_datapath_if #(.W(W)) bus ();

   calc_datapath #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for the whole bench
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ctrl(input logic [1:0] s1, input logic [1:0] wa, input logic we,
                       input logic [1:0] raa, input logic [1:0] rab,
                       input logic rea, input logic reb,
                       input logic [1:0] c, input logic s2);
      bus.s1  = s1;  bus.WA  = wa;  bus.WE  = we;
      bus.RAA = raa; bus.RAB = rab; bus.REA = rea; bus.REB = reb;
      bus.C   = c;   bus.s2  = s2;
   endtask

   task automatic idle();
      ctrl(2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic push(input string tag, input logic [3:0] o, input logic c,
                       input logic z, input logic v, input bit f);
      exp_t e;
      e.tag = tag; e.out = o; e.carry = c; e.zero = z; e.valid = v; e.flags = f;
      sb_q.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
         return;
      end
      e = sb_q.pop_front();
      chk({e.tag, "_out"},   32'(bus.out),   32'(e.out));
      chk({e.tag, "_valid"}, 32'(bus.valid), 32'(e.valid));
      if (e.flags) begin
         chk({e.tag, "_carry"}, 32'(bus.carry), 32'(e.carry));
         chk({e.tag, "_zero"},  32'(bus.zero),  32'(e.zero));
      end
   endtask

   // Reference result of one calculator operation
   task automatic model(input int a, input int b, input logic [1:0] op,
                        output logic [3:0] r, output logic c);
      int t;
      case (op)
         2'd0: begin t = a + b;      c = (t > 15);  end
         2'd1: begin t = a - b + 16; c = (a < b);   end
         2'd2: begin t = a & b;      c = 1'b0;      end
         default: begin t = a ^ b;  c = 1'b0;      end
      endcase
      r = 4'(t);
   endtask

   // Full IDLE..OUTPUT sequence; operands are scrambled after their write edges
   task automatic run_seq(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] op);
      logic [3:0] r;
      logic       c;
      model(int'(a), int'(b), op, r, c);
      push(tag, r, c, (r == 4'd0), 1'b1, 1'b1);
      idle();                                                  step();
      bus.in1 = a; bus.in2 = b;
      ctrl(2'd3, 2'd1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0); step();
      bus.in1 = 4'(~a);
      ctrl(2'd2, 2'd2, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0); step();
      bus.in2 = 4'(~b);
      idle();                                                  step();
      ctrl(2'd0, 2'd3, 1'b1, 2'd1, 2'd2, 1'b1, 1'b1, op, 1'b0); step();
      ctrl(2'd0, 2'd0, 1'b0, 2'd3, 2'd3, 1'b1, 1'b1, 2'd2, 1'b1); step();
      idle();
      pop_check();
   endtask

   // Pass register k to the output through the ALU AND path
   task automatic read_reg(input string tag, input logic [1:0] k, input logic [3:0] v);
      push(tag, v, 1'b0, 1'b0, 1'b1, 1'b0);
      ctrl(2'd0, 2'd0, 1'b0, k, k, 1'b1, 1'b1, 2'd2, 1'b1); step();
      idle();
      pop_check();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.in1 = '0;
      bus.in2 = '0;
      idle();
      step(); step();
      chk("rst_out",   32'(bus.out),   32'd0);
      chk("rst_valid", 32'(bus.valid), 32'd0);
      chk("rst_carry", 32'(bus.carry), 32'd0);
      chk("rst_zero",  32'(bus.zero),  32'd0);
      rst = 1'b0;
      step();

      run_seq("add_wrap", 4'd9, 4'd8, 2'd0);
      run_seq("sub_borrow", 4'd3, 4'd5, 2'd1);
      run_seq("sub_zero", 4'd5, 4'd5, 2'd1);
      run_seq("and", 4'b1100, 4'b1010, 2'd2);
      run_seq("xor", 4'b1100, 4'b1010, 2'd3);

      // Asynchronous reset mid-cycle takes effect before the next edge
      #3 rst = 1'b1;
      #2;
      chk("arst_out",   32'(bus.out),   32'd0);
      chk("arst_valid", 32'(bus.valid), 32'd0);
      chk("arst_carry", 32'(bus.carry), 32'd0);
      chk("arst_zero",  32'(bus.zero),  32'd0);
      step();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) read_reg("rst_rf", 2'(k), 4'd0);

      // Read-before-write on R3, then read-enable gating
      run_seq("r3_two", 4'd1, 4'd1, 2'd0);
      bus.in1 = 4'd7;
      push("rbw_old", 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      ctrl(2'd3, 2'd3, 1'b1, 2'd3, 2'd3, 1'b1, 1'b1, 2'd2, 1'b1); step();
      pop_check();
      read_reg("rbw_new", 2'd3, 4'd7);
      push("rea_off", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      ctrl(2'd0, 2'd0, 1'b0, 2'd3, 2'd3, 1'b0, 1'b0, 2'd0, 1'b1); step();
      idle();
      pop_check();

      // Reset held across the OP edge drops the R3 writeback
      idle(); step();
      bus.in1 = 4'd6; bus.in2 = 4'd3;
      ctrl(2'd3, 2'd1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0); step();
      ctrl(2'd2, 2'd2, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0); step();
      idle(); step();
      ctrl(2'd0, 2'd3, 1'b1, 2'd1, 2'd2, 1'b1, 1'b1, 2'd0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("mop_out",   32'(bus.out),   32'd0);
      chk("mop_valid", 32'(bus.valid), 32'd0);
      step();
      rst = 1'b0;
      idle();
      chk("mop_valid_after", 32'(bus.valid), 32'd0);
      read_reg("mop_r3", 2'd3, 4'd0);
      run_seq("post_rst", 4'd6, 4'd3, 2'd1);

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
